key_debounce_multi: RTL and testbench



---
 rtl/key_debounce_pkg.sv | 25 ++
 rtl/key_debounce_multi_if.sv | 37 +++
 rtl/key_debounce_ch.sv | 141 ++++++++++++++
 rtl/key_debounce_multi.sv | 76 +++++++
 tb/tb_key_debounce_multi.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/key_debounce_pkg.sv
// -----------------------------------------------------------------------------
// key_debounce_pkg
// Shared constants and types for the multi-channel key conditioner.
//   CLK_HZ         : system clock frequency (50 MHz board clock)
//   DEBOUNCE_10MS  : 10 ms of clock cycles, default debounce window
//   HOLD_500MS     : 500 ms of clock cycles, a typical hold-to-repeat delay
//   REPEAT_125MS   : 125 ms of clock cycles, a typical repeat period
//   key_evt_t      : per-channel registered outputs {lvl_n, press, rel}
// Optional feature macro used by the design: KEY_DEBOUNCE_REPEAT_EN
// -----------------------------------------------------------------------------
package key_debounce_pkg;

    localparam int CLK_HZ        = 50_000_000;
    localparam int DEBOUNCE_10MS = CLK_HZ / 100;
    localparam int HOLD_500MS    = CLK_HZ / 2;
    localparam int REPEAT_125MS  = CLK_HZ / 8;

    // "release" is a reserved word, so the release pulse field is named rel.
    typedef struct packed {
        logic lvl_n;   // debounced level, 0 = pressed
        logic press;   // one-cycle press (or repeat) pulse
        logic rel;     // one-cycle release pulse
    } key_evt_t;

endpackage : key_debounce_pkg

// File: rtl/key_debounce_multi_if.sv
// -----------------------------------------------------------------------------
// key_debounce_multi_if
// Bundles the key pins and the conditioned key outputs.
//   key_n       : raw asynchronous key inputs, 0 = pressed
//   key_lvl_n   : debounced stable level, 0 = pressed
//   key_press   : one-cycle press pulses (plus repeat pulses when enabled)
//   key_release : one-cycle release pulses
//   key_any     : registered OR of all debounced pressed states
// Modports: master = key source / consumer side, slave = conditioner.
// -----------------------------------------------------------------------------
interface key_debounce_multi_if #(
    parameter int NUM_KEYS = 4
);

    logic [NUM_KEYS-1:0] key_n;
    logic [NUM_KEYS-1:0] key_lvl_n;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic                key_any;

    modport master (
        output key_n,
        input  key_lvl_n,
        input  key_press,
        input  key_release,
        input  key_any
    );

    modport slave (
        input  key_n,
        output key_lvl_n,
        output key_press,
        output key_release,
        output key_any
    );

endinterface : key_debounce_multi_if

// File: rtl/key_debounce_ch.sv
// -----------------------------------------------------------------------------
// key_debounce_ch
// One key channel: 2-flop synchroniser, symmetric debounce counter, registered
// press/release pulses and, when KEY_DEBOUNCE_REPEAT_EN is defined, a
// hold-to-repeat generator that adds extra press pulses while held.
// Ports:
//   clk50M    : system clock
//   rst_n     : asynchronous active-low reset
//   key_n     : raw asynchronous key input, 0 = pressed
//   evt_q     : registered {lvl_n, press, rel}
//   lvl_n_nxt : next-state debounced level (lets the parent register key_any
//               on the same edge as lvl_n)
// -----------------------------------------------------------------------------
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int CNT_W           = 20,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int HOLD_CYCLES     = 1_000_000,
    parameter int REPEAT_CYCLES   = 250_000
) (
    input  logic     clk50M,
    input  logic     rst_n,
    input  logic     key_n,
    output key_evt_t evt_q,
    output logic     lvl_n_nxt
);

    // Reject configurations whose counters could not reach their terminal count.
    if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1 ||
        ((DEBOUNCE_CYCLES - 1) >> CNT_W) != 0 ||
        ((HOLD_CYCLES - 1) >> CNT_W) != 0 ||
        ((REPEAT_CYCLES - 1) >> CNT_W) != 0) begin : g_cfg_err
        $error("key_debounce_ch: cycle parameters must be >= 1 and fit in CNT_W");
    end

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_q;
    logic             press_d;
    logic             release_q;
    logic             release_d;
    logic             flip_s;
    logic             rpt_s;

    // Debounce: count consecutive disagreements, flip after DEBOUNCE_CYCLES of them.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        flip_s   = 1'b0;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
            stable_d = sync2_q;
            cnt_d    = '0;
            flip_s   = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

`ifdef KEY_DEBOUNCE_REPEAT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    logic [CNT_W-1:0] rpt_cnt_q;
    logic [CNT_W-1:0] rpt_cnt_d;
    logic             hold_done_q;
    logic             hold_done_d;

    // Repeat timer: HOLD_CYCLES to the first repeat, then REPEAT_CYCLES between repeats.
    always_comb begin
        rpt_cnt_d   = rpt_cnt_q;
        hold_done_d = hold_done_q;
        rpt_s       = 1'b0;
        if (stable_q) begin
            // Released (or on the press edge itself): timer idles at zero.
            rpt_cnt_d   = '0;
            hold_done_d = 1'b0;
        end else if (rpt_cnt_q == (hold_done_q ? RPT_LAST : HOLD_LAST)) begin
            rpt_cnt_d   = '0;
            hold_done_d = 1'b1;
            // A release flipping on this same edge wins over the repeat.
            rpt_s       = ~flip_s;
        end else begin
            rpt_cnt_d = rpt_cnt_q + CNT_ONE;
        end
    end

    // Repeat timer state.
    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt_q   <= '0;
            hold_done_q <= 1'b0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            hold_done_q <= hold_done_d;
        end
    end
`else
    assign rpt_s = 1'b0;
`endif

    // Event pulses: a flip to 0 is a press, a flip to 1 is a release.
    always_comb begin
        press_d   = (flip_s & ~sync2_q) | rpt_s;
        release_d = flip_s & sync2_q;
    end

    // Synchroniser, debounce state and registered pulses.
    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            stable_q  <= 1'b1;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= key_n;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign evt_q.lvl_n = stable_q;
    assign evt_q.press = press_q;
    assign evt_q.rel   = release_q;
    assign lvl_n_nxt   = stable_d;

endmodule : key_debounce_ch

// File: rtl/key_debounce_multi.sv
// -----------------------------------------------------------------------------
// key_debounce_multi
// N-channel push-button conditioner between the active-low board KEY pins and
// the game control FSMs. Each channel is an independent key_debounce_ch.
// Optional hold-to-repeat: define KEY_DEBOUNCE_REPEAT_EN.
// Ports:
//   clk50M : system clock, 50 MHz
//   rst_n  : asynchronous active-low reset
//   kif    : key_debounce_multi_if.slave
//              key_n (in), key_lvl_n / key_press / key_release / key_any (out)
// -----------------------------------------------------------------------------
module key_debounce_multi
    import key_debounce_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int CNT_W           = 20,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int HOLD_CYCLES     = 1_000_000,
    parameter int REPEAT_CYCLES   = 250_000
) (
    input  logic                 clk50M,
    input  logic                 rst_n,
    key_debounce_multi_if.slave  kif
);

    if (NUM_KEYS < 1 || NUM_KEYS > 16) begin : g_keys_err
        $error("key_debounce_multi: NUM_KEYS must be 1..16");
    end

    key_evt_t            evt_s [NUM_KEYS];
    logic [NUM_KEYS-1:0] lvl_n_s;
    logic [NUM_KEYS-1:0] press_s;
    logic [NUM_KEYS-1:0] release_s;
    logic [NUM_KEYS-1:0] lvl_n_nxt_s;
    logic                key_any_q;
    logic                key_any_d;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .CNT_W           (CNT_W),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_ch (
            .clk50M    (clk50M),
            .rst_n     (rst_n),
            .key_n     (kif.key_n[i]),
            .evt_q     (evt_s[i]),
            .lvl_n_nxt (lvl_n_nxt_s[i])
        );

        assign lvl_n_s[i]   = evt_s[i].lvl_n;
        assign press_s[i]   = evt_s[i].press;
        assign release_s[i] = evt_s[i].rel;
    end

    // Any key pressed, taken from next stable state so it moves with key_lvl_n.
    always_comb begin
        key_any_d = ~(&lvl_n_nxt_s);
    end

    // key_any register.
    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            key_any_q <= 1'b0;
        end else begin
            key_any_q <= key_any_d;
        end
    end

    assign kif.key_lvl_n   = lvl_n_s;
    assign kif.key_press   = press_s;
    assign kif.key_release = release_s;
    assign kif.key_any     = key_any_q;

endmodule : key_debounce_multi

// File: tb/tb_key_debounce_multi.sv
// -----------------------------------------------------------------------------
// tb_key_debounce_multi
// Self-checking bench: directed table, hand-written corner sequences and
// random stimulus, all compared every cycle against a window-based model.
// -----------------------------------------------------------------------------
module tb_key_debounce_multi;

    localparam int NK   = 4;
    localparam int CW   = 20;
    localparam int DEB  = 8;
    localparam int HOLD = 40;
    localparam int REP  = 10;
`ifdef KEY_DEBOUNCE_REPEAT_EN
    localparam int RPT_EXP = 4;
`else
    localparam int RPT_EXP = 0;
`endif

    logic clk50M = 1'b0;
    logic rst_n  = 1'b0;

    key_debounce_multi_if #(.NUM_KEYS(NK)) kif ();

    key_debounce_multi #(
        .NUM_KEYS        (NK),
        .CNT_W           (CW),
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clk50M (clk50M),
        .rst_n  (rst_n),
        .kif    (kif)
    );

    always #10 clk50M = ~clk50M;

    int errors = 0;
    int checks = 0;
    int press_cnt = 0;
    int rel_cnt   = 0;

    // ---------------- reference model ----------------
    logic [NK-1:0] m_s1, m_s2, m_stable, m_press, m_release;
    logic          m_any;
    int            m_held [NK];
    logic          win [NK][$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1      = '1;
        m_s2      = '1;
        m_stable  = '1;
        m_press   = '0;
        m_release = '0;
        m_any     = 1'b0;
        for (int k = 0; k < NK; k++) begin
            m_held[k] = 0;
            win[k].delete();
        end
    endtask

    // Stable flips once the last DEB synchronised samples all disagree with it.
    task automatic model_edge(input logic [NK-1:0] raw);
        logic [NK-1:0] pre;
        bit all_diff;
        pre       = m_s2;
        m_s2      = m_s1;
        m_s1      = raw;
        m_press   = '0;
        m_release = '0;
        for (int k = 0; k < NK; k++) begin
            win[k].push_back(pre[k]);
            if (win[k].size() > DEB) void'(win[k].pop_front());
            all_diff = (win[k].size() == DEB);
            for (int j = 0; j < win[k].size(); j++)
                if (win[k][j] == m_stable[k]) all_diff = 1'b0;
            if (all_diff) begin
                m_stable[k] = ~m_stable[k];
                if (!m_stable[k]) begin
                    m_press[k] = 1'b1;
                    m_held[k]  = 0;
                end else begin
                    m_release[k] = 1'b1;
                end
            end else if (!m_stable[k]) begin
                m_held[k]++;
            end
`ifdef KEY_DEBOUNCE_REPEAT_EN
            if (!all_diff && !m_stable[k] && m_held[k] >= HOLD &&
                ((m_held[k] - HOLD) % REP) == 0)
                m_press[k] = 1'b1;
`endif
        end
        m_any = |(~m_stable);
    endtask

    // One clock edge: advance the model, then compare all outputs.
    task automatic step();
        @(posedge clk50M);
        if (rst_n) model_edge(kif.key_n);
        #1;
        check("lvl_n",   32'(kif.key_lvl_n),   32'(m_stable));
        check("press",   32'(kif.key_press),   32'(m_press));
        check("release", 32'(kif.key_release), 32'(m_release));
        check("any",     32'(kif.key_any),     32'(m_any));
        press_cnt += $countones(kif.key_press);
        rel_cnt   += $countones(kif.key_release);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_lvl"},     32'(kif.key_lvl_n),   32'hF);
        check({tag, "_press"},   32'(kif.key_press),   32'h0);
        check({tag, "_release"}, 32'(kif.key_release), 32'h0);
        check({tag, "_any"},     32'(kif.key_any),     32'h0);
    endtask

    typedef struct {
        logic [NK-1:0] key_n;
        int            cycles;
        logic [NK-1:0] exp_lvl;
        int            exp_press;
        int            exp_rel;
    } vec_t;

    vec_t tbl [15];
    int   offs [$];
    logic [NK-1:0] rnd_key;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{4'b1111, 12, 4'b1111, 0, 0};
        tbl[1]  = '{4'b1110,  5, 4'b1111, 0, 0};  // short glitch
        tbl[2]  = '{4'b1111,  3, 4'b1111, 0, 0};
        tbl[3]  = '{4'b0000, 12, 4'b0000, 4, 0};  // simultaneous press
        tbl[4]  = '{4'b1111, 12, 4'b1111, 0, 4};  // simultaneous release
        tbl[5]  = '{4'b1101, 10, 4'b1101, 1, 0};  // flips exactly on edge 10
        tbl[6]  = '{4'b1111,  9, 4'b1101, 0, 0};  // one edge short
        tbl[7]  = '{4'b1111,  1, 4'b1111, 0, 1};
        tbl[8]  = '{4'b1101,  5, 4'b1111, 0, 0};  // bounce: low 5
        tbl[9]  = '{4'b1111,  1, 4'b1111, 0, 0};  //         high 1
        tbl[10] = '{4'b1101, 20, 4'b1101, 1, 0};  //         low 20
        tbl[11] = '{4'b1111, 12, 4'b1111, 0, 1};
        tbl[12] = '{4'b0101, 12, 4'b0101, 2, 0};
        tbl[13] = '{4'b1010, 12, 4'b1010, 2, 2};  // press and release together
        tbl[14] = '{4'b1111, 12, 4'b1111, 0, 2};

        // ---- reset ----
        kif.key_n = '1;
        rst_n     = 1'b0;
        model_reset();
        repeat (3) @(posedge clk50M);
        #1;
        check_reset_values("reset");
        @(negedge clk50M);
        rst_n = 1'b1;
        repeat (4) step();

        // ---- clean press / release on key 0 ----
        kif.key_n = 4'b1110;
        for (int e = 1; e <= 11; e++) begin
            step();
            if (e < 10) begin
                check("clean_lvl_early", 32'(kif.key_lvl_n[0]), 32'h1);
            end else if (e == 10) begin
                check("clean_lvl",   32'(kif.key_lvl_n[0]), 32'h0);
                check("clean_press", 32'(kif.key_press[0]), 32'h1);
                check("clean_any",   32'(kif.key_any),      32'h1);
            end else begin
                check("clean_press_once", 32'(kif.key_press[0]), 32'h0);
            end
        end
        kif.key_n = 4'b1111;
        for (int e = 1; e <= 11; e++) begin
            step();
            if (e == 10) begin
                check("rel_lvl",   32'(kif.key_lvl_n[0]),   32'h1);
                check("rel_pulse", 32'(kif.key_release[0]), 32'h1);
                check("rel_any",   32'(kif.key_any),        32'h0);
            end else begin
                check("rel_pulse_once", 32'(kif.key_release[0]), 32'h0);
            end
        end

        // ---- directed table ----
        for (int r = 0; r < 15; r++) begin
            kif.key_n = tbl[r].key_n;
            press_cnt = 0;
            rel_cnt   = 0;
            repeat (tbl[r].cycles) step();
            check($sformatf("tbl%0d_lvl", r),     32'(kif.key_lvl_n), 32'(tbl[r].exp_lvl));
            check($sformatf("tbl%0d_press", r),   32'(press_cnt),     32'(tbl[r].exp_press));
            check($sformatf("tbl%0d_release", r), 32'(rel_cnt),       32'(tbl[r].exp_rel));
        end

        // ---- reset in the middle of a debounce ----
        kif.key_n = 4'b1110;
        repeat (5) step();
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_values("midrst");
        repeat (2) step();
        @(negedge clk50M);
        rst_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            step();
            if (e < 10) check("midrst_lvl_early", 32'(kif.key_lvl_n[0]), 32'h1);
            else        check("midrst_press",     32'(kif.key_press[0]), 32'h1);
        end
        kif.key_n = 4'b1111;
        repeat (12) step();

        // ---- hold-to-repeat on key 2 (release at 68 and at 70, the latter
        //      landing its release flip on the +80 repeat slot) ----
        for (int v = 0; v < 2; v++) begin
            kif.key_n = 4'b1011;
            repeat (10) step();
            check("rpt_press", 32'(kif.key_press[2]), 32'h1);
            offs.delete();
            for (int off = 1; off <= 100; off++) begin
                step();
                if (kif.key_press[2]) offs.push_back(off);
                if (off == 68 + 2 * v) kif.key_n = 4'b1111;
            end
            check("rpt_count", 32'(offs.size()), 32'(RPT_EXP));
            for (int i = 0; i < offs.size() && i < RPT_EXP; i++)
                check("rpt_offset", 32'(offs[i]), 32'(HOLD + i * REP));
            check("rpt_released", 32'(kif.key_lvl_n[2]), 32'h1);
        end

        // ---- random stimulus against the model ----
        rnd_key = '1;
        for (int c = 0; c < 3000; c++) begin
            int p;
            case ((c / 200) % 3)
                0:       p = 2;
                1:       p = 15;
                default: p = 40;
            endcase
            for (int k = 0; k < NK; k++)
                if ($urandom_range(0, 99) < p) rnd_key[k] = ~rnd_key[k];
            kif.key_n = rnd_key;
            if (c == 1500) begin
                #1;
                rst_n = 1'b0;
                model_reset();
                #1;
                check_reset_values("rnd_rst");
                @(negedge clk50M);
                rst_n = 1'b1;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_key_debounce_multi
